id_stage_pipe: RTL and testbench

Parametrised decode stage for the pipelined MIPS datapath. It merges instruction decode, operand selection, branch resolution and the ID/EX pipeline register into one block. It adds behaviour the earlier decode stage lacks: a load-use interlock, a wrong-path squash after taken branches, a downstream hold, and a saturating stall counter. It sits between the IF/ID register and the EX stage, and drives the register-file read addresses combinationally.

---
 rtl/id_stage_pipe_pkg.sv | 26 ++
 rtl/id_ctrl_decode.sv | 49 ++++
 rtl/id_stage_pipe.sv | 176 +++++++++++++++++
 tb/tb_id_stage_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: opcodes, ALU operation codes and
// the branch-condition classes produced by the control decoder.
package id_pkg;

   localparam logic [5:0] OP_NOP  = 6'd0;
   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd3;
   localparam logic [5:0] OP_ADDI = 6'd32;
   localparam logic [5:0] OP_LD   = 6'd36;
   localparam logic [5:0] OP_ST   = 6'd37;
   localparam logic [5:0] OP_BEZ  = 6'd40;
   localparam logic [5:0] OP_BNE  = 6'd41;
   localparam logic [5:0] OP_JMP  = 6'd42;

   localparam logic [3:0] ALU_NONE = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;

   typedef enum logic [1:0] {
      BR_NONE   = 2'd0,
      BR_EQZ    = 2'd1,
      BR_NE     = 2'd2,
      BR_ALWAYS = 2'd3
   } br_type_e;

endpackage

// File: rtl/id_ctrl_decode.sv
// Purely combinational opcode-to-control decode. An invalid slot or an
// unrecognised opcode yields the all-quiet NOP control word.
module id_ctrl_decode
   import id_pkg::*;
(
   input  logic       valid_i,
   input  logic [5:0] opcode_i,
   output logic [3:0] alu_op_o,
   output logic       imm_sel_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       wb_en_o,
   output logic       uses_src2_o,
   output logic       rs2_from_dest_o,
   output logic [1:0] br_type_o
);

   // Opcode table; anything not listed stays a NOP.
   always_comb begin
      alu_op_o        = ALU_NONE;
      imm_sel_o       = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      wb_en_o         = 1'b0;
      uses_src2_o     = 1'b0;
      rs2_from_dest_o = 1'b0;
      br_type_o       = BR_NONE;
      if (valid_i) begin
         case (opcode_i)
            OP_ADD:  begin alu_op_o = ALU_ADD; wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_SUB:  begin alu_op_o = ALU_SUB; wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_ADDI: begin alu_op_o = ALU_ADD; imm_sel_o = 1'b1; wb_en_o = 1'b1; end
            OP_LD:   begin alu_op_o = ALU_ADD; imm_sel_o = 1'b1; mem_read_o = 1'b1; wb_en_o = 1'b1; end
            OP_ST:   begin
               alu_op_o        = ALU_ADD;
               imm_sel_o       = 1'b1;
               mem_write_o     = 1'b1;
               uses_src2_o     = 1'b1;
               rs2_from_dest_o = 1'b1;
            end
            OP_BEZ:  br_type_o = BR_EQZ;
            OP_BNE:  begin br_type_o = BR_NE; uses_src2_o = 1'b1; rs2_from_dest_o = 1'b1; end
            OP_JMP:  br_type_o = BR_ALWAYS;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with ID/EX register: operand selection, branch resolution,
// load-use interlock, wrong-path squash, downstream hold and a saturating
// stall counter.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] pc_plus4,
   input  logic [DATA_W-1:0] rf_rd1_data,
   input  logic [DATA_W-1:0] rf_rd2_data,
   input  logic              ex_hold,
   output logic [REG_AW-1:0] rf_rs1_addr,
   output logic [REG_AW-1:0] rf_rs2_addr,
   output logic              stall,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target,
   output logic              ex_valid,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_wb_en,
   output logic              ex_imm_sel,
   output logic [3:0]        ex_alu_op,
   output logic [DATA_W-1:0] ex_val1,
   output logic [DATA_W-1:0] ex_val2,
   output logic [DATA_W-1:0] ex_st_data,
   output logic [REG_AW-1:0] ex_dest,
   output logic [REG_AW-1:0] ex_src1,
   output logic [REG_AW-1:0] ex_src2_fwd,
   output logic [CNT_W-1:0]  stall_count
);

   logic [3:0]        alu_op;
   logic              imm_sel, mem_read, mem_write, wb_en, uses_src2, rs2_from_dest;
   logic [1:0]        br_type_raw;
   br_type_e          br_type;
   logic [REG_AW-1:0] rs1, rs2, dest;
   logic [DATA_W-1:0] imm_ext;
   logic              load_use, br_cond, bubble;

   logic              ex_valid_q, ex_valid_d, ex_mem_read_q, ex_mem_read_d;
   logic              ex_mem_write_q, ex_mem_write_d, ex_wb_en_q, ex_wb_en_d;
   logic              ex_imm_sel_q, ex_imm_sel_d, squash_q, squash_d;
   logic [3:0]        ex_alu_op_q, ex_alu_op_d;
   logic [DATA_W-1:0] ex_val1_q, ex_val1_d, ex_val2_q, ex_val2_d, ex_st_data_q, ex_st_data_d;
   logic [REG_AW-1:0] ex_dest_q, ex_dest_d, ex_src1_q, ex_src1_d, ex_src2_fwd_q, ex_src2_fwd_d;
   logic [CNT_W-1:0]  stall_count_q, stall_count_d;

   id_ctrl_decode u_ctrl_decode (
      .valid_i         (instr_valid),
      .opcode_i        (instruction[31:26]),
      .alu_op_o        (alu_op),
      .imm_sel_o       (imm_sel),
      .mem_read_o      (mem_read),
      .mem_write_o     (mem_write),
      .wb_en_o         (wb_en),
      .uses_src2_o     (uses_src2),
      .rs2_from_dest_o (rs2_from_dest),
      .br_type_o       (br_type_raw)
   );

   assign br_type = br_type_e'(br_type_raw);
   assign rs1     = REG_AW'(instruction[20:16]);
   assign dest    = REG_AW'(instruction[25:21]);
   assign rs2     = rs2_from_dest ? REG_AW'(instruction[25:21]) : REG_AW'(instruction[15:11]);
   assign imm_ext = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};

   // Hazard, branch resolution and stall; hold and squash take precedence.
   always_comb begin
      load_use = instr_valid & ex_valid_q & ex_mem_read_q & (ex_dest_q != '0) &
                 ((ex_dest_q == rs1) | (uses_src2 & (ex_dest_q == rs2)));
      case (br_type)
         BR_EQZ:    br_cond = (rf_rd1_data == '0);
         BR_NE:     br_cond = (rf_rd1_data != rf_rd2_data);
         BR_ALWAYS: br_cond = 1'b1;
         default:   br_cond = 1'b0;
      endcase
      branch_taken = ~ex_hold & ~squash_q & ~load_use & br_cond;
      stall        = ex_hold | (~squash_q & load_use);
      bubble       = squash_q | load_use;
   end

   // ID/EX next state: frozen under hold, otherwise decoded (or bubbled).
   always_comb begin
      ex_valid_d     = ex_valid_q;
      ex_mem_read_d  = ex_mem_read_q;
      ex_mem_write_d = ex_mem_write_q;
      ex_wb_en_d     = ex_wb_en_q;
      ex_imm_sel_d   = ex_imm_sel_q;
      ex_alu_op_d    = ex_alu_op_q;
      ex_val1_d      = ex_val1_q;
      ex_val2_d      = ex_val2_q;
      ex_st_data_d   = ex_st_data_q;
      ex_dest_d      = ex_dest_q;
      ex_src1_d      = ex_src1_q;
      ex_src2_fwd_d  = ex_src2_fwd_q;
      squash_d       = squash_q;
      if (!ex_hold) begin
         // Any squash is consumed here; branch_taken is already 0 while squashing.
         squash_d       = branch_taken;
         ex_valid_d     = instr_valid & ~bubble;
         ex_mem_read_d  = mem_read & ~bubble;
         ex_mem_write_d = mem_write & ~bubble;
         ex_wb_en_d     = wb_en & ~bubble;
         ex_imm_sel_d   = imm_sel;
         ex_alu_op_d    = alu_op;
         ex_val1_d      = rf_rd1_data;
         ex_val2_d      = imm_sel ? imm_ext : rf_rd2_data;
         ex_st_data_d   = rf_rd2_data;
         ex_dest_d      = dest;
         ex_src1_d      = rs1;
         // Stores still need their data register forwarded.
         ex_src2_fwd_d  = (imm_sel & ~mem_write) ? '0 : rs2;
      end
      stall_count_d = (stall && (stall_count_q != {CNT_W{1'b1}})) ? stall_count_q + 1'b1 : stall_count_q;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q     <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_mem_write_q <= 1'b0;
         ex_wb_en_q     <= 1'b0;
         ex_imm_sel_q   <= 1'b0;
         ex_alu_op_q    <= '0;
         ex_val1_q      <= '0;
         ex_val2_q      <= '0;
         ex_st_data_q   <= '0;
         ex_dest_q      <= '0;
         ex_src1_q      <= '0;
         ex_src2_fwd_q  <= '0;
         squash_q       <= 1'b0;
         stall_count_q  <= '0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_mem_read_q  <= ex_mem_read_d;
         ex_mem_write_q <= ex_mem_write_d;
         ex_wb_en_q     <= ex_wb_en_d;
         ex_imm_sel_q   <= ex_imm_sel_d;
         ex_alu_op_q    <= ex_alu_op_d;
         ex_val1_q      <= ex_val1_d;
         ex_val2_q      <= ex_val2_d;
         ex_st_data_q   <= ex_st_data_d;
         ex_dest_q      <= ex_dest_d;
         ex_src1_q      <= ex_src1_d;
         ex_src2_fwd_q  <= ex_src2_fwd_d;
         squash_q       <= squash_d;
         stall_count_q  <= stall_count_d;
      end
   end

   assign rf_rs1_addr   = rs1;
   assign rf_rs2_addr   = rs2;
   assign branch_target = pc_plus4 + (imm_ext << 2);
   assign ex_valid      = ex_valid_q;
   assign ex_mem_read   = ex_mem_read_q;
   assign ex_mem_write  = ex_mem_write_q;
   assign ex_wb_en      = ex_wb_en_q;
   assign ex_imm_sel    = ex_imm_sel_q;
   assign ex_alu_op     = ex_alu_op_q;
   assign ex_val1       = ex_val1_q;
   assign ex_val2       = ex_val2_q;
   assign ex_st_data    = ex_st_data_q;
   assign ex_dest       = ex_dest_q;
   assign ex_src1       = ex_src1_q;
   assign ex_src2_fwd   = ex_src2_fwd_q;
   assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios with fixed expectations plus a
// randomized run against a behavioural model of the decode-stage rules.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instruction = '0;
   logic [31:0] pc_plus4 = '0, rf_rd1_data = '0, rf_rd2_data = '0;
   logic        ex_hold = 1'b0;
   logic [4:0]  rf_rs1_addr, rf_rs2_addr;
   logic        stall, branch_taken;
   logic [31:0] branch_target;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_imm_sel;
   logic [3:0]  ex_alu_op;
   logic [31:0] ex_val1, ex_val2, ex_st_data;
   logic [4:0]  ex_dest, ex_src1, ex_src2_fwd;
   logic [15:0] stall_count;

   int n_cmp = 0;
   int n_bad = 0;

   id_stage_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
      .pc_plus4(pc_plus4), .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
      .ex_hold(ex_hold), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_wb_en(ex_wb_en), .ex_imm_sel(ex_imm_sel), .ex_alu_op(ex_alu_op),
      .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_st_data(ex_st_data),
      .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2_fwd(ex_src2_fwd),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input int op, input int d, input int s1, input int imm);
      logic [31:0] r;
      r = {op[5:0], d[4:0], s1[4:0], imm[15:0]};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2, input logic hold);
      instr_valid = v; instruction = ins; pc_plus4 = pc;
      rf_rd1_data = r1; rf_rd2_data = r2; ex_hold = hold;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply(1'b0, '0, '0, '0, '0, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      apply(1'b1, mk(42, 1, 2, 3), 32'h40, 32'h5, 32'h6, 1'b1);
      tick();
      tick();
      n_cmp++; if ({ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_imm_sel, ex_alu_op, ex_val1, ex_val2, ex_st_data, ex_dest, ex_src1, ex_src2_fwd} !== '0) begin n_bad++; $display("FAIL reset_ex_outputs: ex_valid=%0b val1=%h val2=%h dest=%0d, required all zero", ex_valid, ex_val1, ex_val2, ex_dest); end
      n_cmp++; if (stall_count !== 16'd0) begin n_bad++; $display("FAIL reset_stall_count: got %0d required 0", stall_count); end
      rst = 1'b0;
      $display("reset: ex outputs and stall_count checked");
   endtask

   task automatic test_addi();
      do_reset();
      apply(1'b1, mk(32, 2, 3, 16'hFFFC), 32'h10, 32'd10, 32'd77, 1'b0);
      n_cmp++; if (rf_rs1_addr !== 5'd3) begin n_bad++; $display("FAIL addi_rs1: got %0d required 3", rf_rs1_addr); end
      n_cmp++; if ({stall, branch_taken} !== 2'b00) begin n_bad++; $display("FAIL addi_stall_branch: got %b required 00", {stall, branch_taken}); end
      tick();
      n_cmp++; if (ex_val2 !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL addi_val2: got %h required fffffffc", ex_val2); end
      n_cmp++; if (ex_val1 !== 32'd10) begin n_bad++; $display("FAIL addi_val1: got %0d required 10", ex_val1); end
      n_cmp++; if ({ex_valid, ex_alu_op, ex_imm_sel, ex_wb_en, ex_mem_read, ex_mem_write} !== {1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL addi_ctrl: valid=%b alu=%0d imm=%b wb=%b mr=%b mw=%b required 1,1,1,1,0,0", ex_valid, ex_alu_op, ex_imm_sel, ex_wb_en, ex_mem_read, ex_mem_write); end
      n_cmp++; if ({ex_src2_fwd, ex_dest, ex_src1} !== {5'd0, 5'd2, 5'd3}) begin n_bad++; $display("FAIL addi_fields: src2_fwd=%0d dest=%0d src1=%0d required 0,2,3", ex_src2_fwd, ex_dest, ex_src1); end
      $display("addi: r2 <= r3 + -4 checked");
   endtask

   task automatic test_load_use();
      do_reset();
      apply(1'b1, mk(36, 5, 1, 8), 32'h20, 32'h1000, 32'h0, 1'b0);
      tick();
      n_cmp++; if ({ex_valid, ex_mem_read, ex_dest} !== {1'b1, 1'b1, 5'd5}) begin n_bad++; $display("FAIL ld_issue: valid=%b mr=%b dest=%0d required 1,1,5", ex_valid, ex_mem_read, ex_dest); end
      apply(1'b1, mk(1, 6, 5, 1 << 11), 32'h24, 32'h3, 32'h4, 1'b0);
      n_cmp++; if ({stall, branch_taken} !== 2'b10) begin n_bad++; $display("FAIL ldu_stall: stall/taken got %b required 10", {stall, branch_taken}); end
      tick();
      n_cmp++; if ({ex_valid, ex_mem_read, ex_wb_en} !== 3'b000) begin n_bad++; $display("FAIL ldu_bubble: valid/mr/wb got %b required 000", {ex_valid, ex_mem_read, ex_wb_en}); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ldu_single_stall: stall got %b required 0", stall); end
      tick();
      n_cmp++; if ({ex_valid, ex_alu_op, ex_dest, ex_src1, ex_src2_fwd} !== {1'b1, 4'd1, 5'd6, 5'd5, 5'd1}) begin n_bad++; $display("FAIL ldu_add_issue: valid=%b alu=%0d dest=%0d src1=%0d src2=%0d required 1,1,6,5,1", ex_valid, ex_alu_op, ex_dest, ex_src1, ex_src2_fwd); end
      n_cmp++; if (stall_count !== 16'd1) begin n_bad++; $display("FAIL ldu_count: got %0d required 1", stall_count); end
      $display("load_use: LD r5 then ADD r6=r5+r1 checked");
   endtask

   task automatic test_branch();
      do_reset();
      apply(1'b1, mk(41, 4, 3, 2), 32'h100, 32'd3, 32'd4, 1'b0);
      n_cmp++; if ({branch_taken, stall} !== 2'b10) begin n_bad++; $display("FAIL bne_taken: taken/stall got %b required 10", {branch_taken, stall}); end
      n_cmp++; if (branch_target !== 32'h108) begin n_bad++; $display("FAIL bne_target: got %h required 108", branch_target); end
      n_cmp++; if ({rf_rs1_addr, rf_rs2_addr} !== {5'd3, 5'd4}) begin n_bad++; $display("FAIL bne_addr: rs1=%0d rs2=%0d required 3,4", rf_rs1_addr, rf_rs2_addr); end
      tick();
      n_cmp++; if ({ex_valid, ex_wb_en, ex_src2_fwd} !== {1'b1, 1'b0, 5'd4}) begin n_bad++; $display("FAIL bne_issue: valid=%b wb=%b src2=%0d required 1,0,4", ex_valid, ex_wb_en, ex_src2_fwd); end
      apply(1'b1, mk(32, 7, 1, 5), 32'h104, 32'd1, 32'd1, 1'b0);
      n_cmp++; if ({branch_taken, stall} !== 2'b00) begin n_bad++; $display("FAIL squash_comb: taken/stall got %b required 00", {branch_taken, stall}); end
      tick();
      n_cmp++; if ({ex_valid, ex_wb_en} !== 2'b00) begin n_bad++; $display("FAIL squash_bubble: valid/wb got %b required 00", {ex_valid, ex_wb_en}); end
      tick();
      n_cmp++; if ({ex_valid, ex_dest} !== {1'b1, 5'd7}) begin n_bad++; $display("FAIL post_squash: valid=%b dest=%0d required 1,7", ex_valid, ex_dest); end
      $display("branch: BNE taken to 108 with one squashed slot checked");
   endtask

   task automatic test_hold();
      do_reset();
      apply(1'b1, mk(1, 9, 1, 2 << 11), 32'h30, 32'd5, 32'd6, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, mk(42, 0, 0, 0), 32'h34, 32'd8, 32'd9, 1'b1);
         n_cmp++; if ({stall, branch_taken} !== 2'b10) begin n_bad++; $display("FAIL hold_comb[%0d]: stall/taken got %b required 10", i, {stall, branch_taken}); end
         tick();
         n_cmp++; if ({ex_valid, ex_alu_op, ex_val1, ex_val2, ex_dest, ex_wb_en} !== {1'b1, 4'd1, 32'd5, 32'd6, 5'd9, 1'b1}) begin n_bad++; $display("FAIL hold_frozen[%0d]: valid=%b alu=%0d val1=%0d val2=%0d dest=%0d required 1,1,5,6,9", i, ex_valid, ex_alu_op, ex_val1, ex_val2, ex_dest); end
      end
      n_cmp++; if (stall_count !== 16'd3) begin n_bad++; $display("FAIL hold_count: got %0d required 3", stall_count); end
      $display("hold: three frozen cycles checked");
   endtask

   task automatic test_r0_and_unknown();
      do_reset();
      apply(1'b1, mk(36, 0, 1, 0), 32'h0, 32'd0, 32'd0, 1'b0);
      tick();
      apply(1'b1, mk(1, 1, 0, 0), 32'h4, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ld_r0_nostall: stall got %b required 0", stall); end
      tick();
      n_cmp++; if ({ex_valid, ex_wb_en} !== 2'b11) begin n_bad++; $display("FAIL ld_r0_issue: valid/wb got %b required 11", {ex_valid, ex_wb_en}); end
      apply(1'b1, mk(63, 3, 4, 16'h1234), 32'h8, 32'd0, 32'd0, 1'b0);
      tick();
      n_cmp++; if ({ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_alu_op} !== {1'b1, 3'b000, 4'd0}) begin n_bad++; $display("FAIL op63_nop: valid=%b mr=%b mw=%b wb=%b alu=%0d required 1,0,0,0,0", ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_alu_op); end
      apply(1'b0, mk(42, 0, 0, 0), 32'hC, 32'd0, 32'd0, 1'b0);
      n_cmp++; if ({branch_taken, stall} !== 2'b00) begin n_bad++; $display("FAIL invalid_quiet: taken/stall got %b required 00", {branch_taken, stall}); end
      tick();
      n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL invalid_bubble: ex_valid got %b required 0", ex_valid); end
      $display("r0_unknown: LD r0 use, opcode 63, invalid slot checked");
   endtask

   task automatic test_hold_during_squash();
      do_reset();
      apply(1'b1, mk(42, 0, 0, 3), 32'h50, 32'd0, 32'd0, 1'b0);
      tick();
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, mk(32, 7, 1, 1), 32'h54, 32'd0, 32'd0, 1'b1);
         tick();
         n_cmp++; if ({ex_valid, ex_wb_en} !== 2'b10) begin n_bad++; $display("FAIL hsq_frozen[%0d]: valid/wb got %b required 10", i, {ex_valid, ex_wb_en}); end
      end
      apply(1'b1, mk(32, 7, 1, 1), 32'h54, 32'd0, 32'd0, 1'b0);
      n_cmp++; if ({stall, branch_taken} !== 2'b00) begin n_bad++; $display("FAIL hsq_release: stall/taken got %b required 00", {stall, branch_taken}); end
      tick();
      n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL hsq_squashed: ex_valid got %b required 0", ex_valid); end
      tick();
      n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL hsq_resume: ex_valid got %b required 1", ex_valid); end
      $display("hold_during_squash: squash retained across hold checked");
   endtask

   task automatic test_branch_vs_load_use();
      do_reset();
      apply(1'b1, mk(36, 5, 1, 8), 32'h1FC, 32'd0, 32'd0, 1'b0);
      tick();
      apply(1'b1, mk(40, 0, 5, 4), 32'h200, 32'd0, 32'd1, 1'b0);
      n_cmp++; if ({stall, branch_taken} !== 2'b10) begin n_bad++; $display("FAIL brlu_stall_wins: stall/taken got %b required 10", {stall, branch_taken}); end
      tick();
      n_cmp++; if ({ex_valid, stall, branch_taken} !== 3'b001) begin n_bad++; $display("FAIL brlu_resolve: valid/stall/taken got %b required 001", {ex_valid, stall, branch_taken}); end
      n_cmp++; if (branch_target !== 32'h210) begin n_bad++; $display("FAIL brlu_target: got %h required 210", branch_target); end
      tick();
      n_cmp++; if ({ex_valid, ex_alu_op} !== {1'b1, 4'd0}) begin n_bad++; $display("FAIL brlu_issue: valid=%b alu=%0d required 1,0", ex_valid, ex_alu_op); end
      $display("branch_vs_load_use: stall first, branch next cycle checked");
   endtask

   task automatic test_reset_mid_squash();
      do_reset();
      apply(1'b1, mk(42, 0, 0, 0), 32'h60, 32'd0, 32'd0, 1'b0);
      tick();
      rst = 1'b1;
      apply(1'b1, mk(32, 7, 1, 1), 32'h64, 32'd0, 32'd0, 1'b1);
      tick();
      n_cmp++; if ({ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_imm_sel, ex_alu_op, ex_val1, ex_val2, ex_dest, ex_src1, ex_src2_fwd, stall_count} !== '0) begin n_bad++; $display("FAIL rst_mid_squash: valid=%b alu=%0d count=%0d required all zero", ex_valid, ex_alu_op, stall_count); end
      rst = 1'b0;
      apply(1'b1, mk(32, 7, 1, 1), 32'h64, 32'd0, 32'd0, 1'b0);
      tick();
      n_cmp++; if ({ex_valid, ex_dest} !== {1'b1, 5'd7}) begin n_bad++; $display("FAIL rst_clears_squash: valid=%b dest=%0d required 1,7", ex_valid, ex_dest); end
      $display("reset_mid_squash: squash cleared by reset checked");
   endtask

   task automatic test_saturate();
      do_reset();
      apply(1'b0, '0, '0, '0, '0, 1'b1);
      repeat (65534) tick();
      n_cmp++; if (stall_count !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre: got %h required fffe", stall_count); end
      tick();
      n_cmp++; if (stall_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_full: got %h required ffff", stall_count); end
      repeat (3) tick();
      n_cmp++; if (stall_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_nowrap: got %h required ffff", stall_count); end
      ex_hold = 1'b0;
      $display("saturate: stall_count pinned at ffff checked");
   endtask

   // Randomized run against a model of the stage described as "last issued
   // instruction + pending squash + stall total".
   task automatic test_random();
      int ops[11] = '{0, 1, 3, 32, 36, 37, 40, 41, 42, 63, 17};
      logic m_valid, m_mr, m_mw, m_wb, m_imm, m_squash;
      int m_alu, m_dest, m_src1, m_src2f, m_cnt;
      logic [31:0] m_v1, m_v2, m_st;
      int op, rs1, rs2, imm, fail0;
      logic v, hold, hz, cond, e_taken, e_stall, is_imm, uses2, m_issue;
      logic [31:0] ins, pc, r1, r2, e_tgt, sext;
      logic signed [15:0] simm;
      do_reset();
      m_valid = 0; m_mr = 0; m_mw = 0; m_wb = 0; m_imm = 0; m_squash = 0;
      m_alu = 0; m_dest = 0; m_src1 = 0; m_src2f = 0; m_cnt = 0; m_v1 = 0; m_v2 = 0; m_st = 0;
      fail0 = n_bad;
      for (int c = 0; c < 400; c++) begin
         op = ops[$urandom_range(0, 10)];
         imm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : (int'($urandom_range(0, 3)) << 11) | int'($urandom_range(0, 2047));
         ins = mk(op, $urandom_range(0, 3), $urandom_range(0, 3), imm);
         v = ($urandom_range(0, 99) < 85);
         hold = ($urandom_range(0, 99) < 12);
         pc = $urandom & 32'hFFFF_FFFC;
         r1 = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
         r2 = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
         apply(v, ins, pc, r1, r2, hold);
         op = v ? int'(ins[31:26]) : 0;
         is_imm = (op == 32 || op == 36 || op == 37);
         uses2 = (op == 1 || op == 3 || op == 37 || op == 41);
         rs1 = int'(ins[20:16]);
         rs2 = (op == 37 || op == 41) ? int'(ins[25:21]) : int'(ins[15:11]);
         hz = v && m_valid && m_mr && m_dest != 0 && (m_dest == rs1 || (uses2 && m_dest == rs2));
         cond = (op == 40) ? (r1 == 0) : (op == 41) ? (r1 != r2) : (op == 42);
         e_taken = !hold && !m_squash && !hz && cond;
         e_stall = hold || (!m_squash && hz);
         simm = ins[15:0];
         sext = 32'(int'(simm));
         e_tgt = pc + 32'(int'(simm) * 4);
         n_cmp++; if ({branch_taken, stall} !== {e_taken, e_stall}) begin n_bad++; $display("FAIL rnd_comb[%0d]: taken/stall got %b required %b (op=%0d)", c, {branch_taken, stall}, {e_taken, e_stall}, op); end
         n_cmp++; if (branch_target !== e_tgt) begin n_bad++; $display("FAIL rnd_target[%0d]: got %h required %h", c, branch_target, e_tgt); end
         if (v) begin
            n_cmp++; if ({rf_rs1_addr, rf_rs2_addr} !== {5'(rs1), 5'(rs2)}) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %0d,%0d required %0d,%0d", c, rf_rs1_addr, rf_rs2_addr, rs1, rs2); end
         end
         tick();
         if (e_stall && m_cnt < 65535) m_cnt++;
         if (!hold) begin
            m_issue = !(m_squash || hz);
            m_squash = e_taken;
            m_valid = v && m_issue;
            m_mr = m_issue && op == 36;
            m_mw = m_issue && op == 37;
            m_wb = m_issue && (op == 1 || op == 3 || op == 32 || op == 36);
            m_imm = is_imm;
            m_alu = (op == 3) ? 2 : (op == 1 || is_imm) ? 1 : 0;
            m_v1 = r1;
            m_v2 = is_imm ? sext : r2;
            m_st = r2;
            m_dest = int'(ins[25:21]);
            m_src1 = rs1;
            m_src2f = (is_imm && op != 37) ? 0 : rs2;
         end
         n_cmp++; if ({ex_valid, ex_mem_read, ex_mem_write, ex_wb_en} !== {m_valid, m_mr, m_mw, m_wb}) begin n_bad++; $display("FAIL rnd_ctrl[%0d]: v/mr/mw/wb got %b required %b", c, {ex_valid, ex_mem_read, ex_mem_write, ex_wb_en}, {m_valid, m_mr, m_mw, m_wb}); end
         if (m_valid) begin
            n_cmp++; if ({ex_alu_op, ex_imm_sel, ex_val1, ex_val2, ex_st_data} !== {4'(m_alu), m_imm, m_v1, m_v2, m_st}) begin n_bad++; $display("FAIL rnd_data[%0d]: alu=%0d imm=%b v1=%h v2=%h st=%h required %0d,%b,%h,%h,%h", c, ex_alu_op, ex_imm_sel, ex_val1, ex_val2, ex_st_data, m_alu, m_imm, m_v1, m_v2, m_st); end
            n_cmp++; if ({ex_dest, ex_src1, ex_src2_fwd} !== {5'(m_dest), 5'(m_src1), 5'(m_src2f)}) begin n_bad++; $display("FAIL rnd_regs[%0d]: dest=%0d src1=%0d src2=%0d required %0d,%0d,%0d", c, ex_dest, ex_src1, ex_src2_fwd, m_dest, m_src1, m_src2f); end
         end
      end
      n_cmp++; if (stall_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_count: got %0d required %0d", stall_count, m_cnt); end
      $display("random: 400 cycles, %0d new mismatches", n_bad - fail0);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_load_use();
      test_branch();
      test_hold();
      test_r0_and_unknown();
      test_hold_during_squash();
      test_branch_vs_load_use();
      test_reset_mid_squash();
      test_random();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
